// File: rtl/hazard_fwd_unit_pkg.sv
// Shared pipeline definitions: hazard FSM state codes and operand forward-select encodings.
package hazard_fwd_unit_pkg;

  localparam int unsigned ST_W = 2;
  typedef logic [ST_W-1:0] fsm_state_t;

  localparam fsm_state_t ST_RUN      = 2'b00;
  localparam fsm_state_t ST_LU_STALL = 2'b01;
  localparam fsm_state_t ST_MEM_WAIT = 2'b10;

  localparam int unsigned FWD_W = 2;
  typedef logic [FWD_W-1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_MWB = 2'b01;
  localparam fwd_sel_t FWD_XM  = 2'b10;

endpackage

// File: rtl/hazard_fwd_unit_fwd_sel.sv
// Operand forward select for one EX source: EX/MEM wins over MEM/WB, else register file.
module fwd_sel
  import hazard_fwd_unit_pkg::*;
#(
  parameter int unsigned REG_AW   = 3,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic [REG_AW-1:0] src,
  input  logic              src_v,
  input  logic [REG_AW-1:0] xm_rd,
  input  logic              xm_wr,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic              mwb_wr,
  output fwd_sel_t          sel
);

  logic src_live;
  logic xm_hit;
  logic mwb_hit;

  // A hardwired-zero source never needs a forwarded value.
  assign src_live = src_v & ~(ZERO_REG & (src == '0));
  assign xm_hit   = src_live & xm_wr  & (xm_rd  == src);
  assign mwb_hit  = src_live & mwb_wr & (mwb_rd == src);

  always_comb begin
    sel = FWD_RF;
    if (xm_hit) begin
      sel = FWD_XM;
    end else if (mwb_hit) begin
      sel = FWD_MWB;
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Pipeline hazard unit: operand forwarding, load-use stall/bubble, memory freeze, stall counter.
module hazard_fwd_unit
  import hazard_fwd_unit_pkg::*;
#(
  parameter int unsigned REG_AW   = 3,
  parameter bit          ZERO_REG = 1'b0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_v,
  input  logic              id_rt_v,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              ex_rs_v,
  input  logic              ex_rt_v,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_wr,
  input  logic              ex_ld,
  input  logic [REG_AW-1:0] xm_rd,
  input  logic              xm_wr,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic              mwb_wr,
  input  logic              mem_busy,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stall_fe,
  output logic              bubble_ex,
  output logic              freeze,
  output logic [CNT_W-1:0]  stall_cnt
);

  fsm_state_t state;
  fsm_state_t state_nxt;
  logic       pend;
  logic       pend_nxt;
  logic       lu_hit;
  logic       lu_stall;
  logic       stall_fe_nxt;
  logic       bubble_ex_nxt;
  logic       freeze_nxt;
  logic       ex_rd_live;

  fwd_sel #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_fwd_a (
    .src    (ex_rs),
    .src_v  (ex_rs_v),
    .xm_rd  (xm_rd),
    .xm_wr  (xm_wr),
    .mwb_rd (mwb_rd),
    .mwb_wr (mwb_wr),
    .sel    (fwd_a)
  );

  fwd_sel #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_fwd_b (
    .src    (ex_rt),
    .src_v  (ex_rt_v),
    .xm_rd  (xm_rd),
    .xm_wr  (xm_wr),
    .mwb_rd (mwb_rd),
    .mwb_wr (mwb_wr),
    .sel    (fwd_b)
  );

  // A load into the hardwired-zero register can never create a dependency.
  assign ex_rd_live = ex_ld & ex_wr & ~(ZERO_REG & (ex_rd == '0));
  assign lu_hit     = ex_rd_live & ((id_rs_v & (id_rs == ex_rd)) |
                                    (id_rt_v & (id_rt == ex_rd)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      pend  <= 1'b0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
    end
  end

  // Next state plus Mealy stall decode; freeze masks the bubble but keeps the front end held.
  always_comb begin
    state_nxt     = state;
    pend_nxt      = pend;
    lu_stall      = 1'b0;
    case (state)
      ST_RUN: begin
        lu_stall = lu_hit;
        if (mem_busy) begin
          state_nxt = ST_MEM_WAIT;
          pend_nxt  = lu_hit;
        end else if (lu_hit) begin
          state_nxt = ST_LU_STALL;
        end
      end
      ST_LU_STALL: begin
        lu_stall = 1'b1;
        if (mem_busy) begin
          state_nxt = ST_MEM_WAIT;
          pend_nxt  = 1'b1;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_busy) begin
          state_nxt = pend ? ST_LU_STALL : ST_RUN;
          pend_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = ST_RUN;
        pend_nxt  = 1'b0;
      end
    endcase
    freeze_nxt    = mem_busy;
    stall_fe_nxt  = mem_busy | lu_stall;
    bubble_ex_nxt = lu_stall & ~mem_busy;
  end

  assign freeze    = rst_n & freeze_nxt;
  assign stall_fe  = rst_n & stall_fe_nxt;
  assign bubble_ex = rst_n & bubble_ex_nxt;

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if ((stall_fe_nxt | freeze_nxt) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench: default instance and a ZERO_REG=1/CNT_W=4 instance against a cycle model.
module tb_hazard_fwd_unit;

  logic       clk;
  logic       rst_n;
  logic [2:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, xm_rd, mwb_rd;
  logic       id_rs_v, id_rt_v, ex_rs_v, ex_rt_v, ex_wr, ex_ld, xm_wr, mwb_wr, mem_busy;

  logic [1:0]  fa [2];
  logic [1:0]  fb [2];
  logic        sf [2];
  logic        bx [2];
  logic        fz [2];
  logic [15:0] c0;
  logic [3:0]  c1;

  int checks   = 0;
  int failures = 0;

  // Reference model state per instance: bubbles owed, memory busy last cycle, stall count.
  int owe [2];
  int pb  [2];
  int cnt [2];
  int cmax [2] = '{65535, 15};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hazard_fwd_unit u_dut0 (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_rs_v(id_rs_v), .id_rt_v(id_rt_v),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rs_v(ex_rs_v), .ex_rt_v(ex_rt_v), .ex_rd(ex_rd),
    .ex_wr(ex_wr), .ex_ld(ex_ld), .xm_rd(xm_rd), .xm_wr(xm_wr), .mwb_rd(mwb_rd), .mwb_wr(mwb_wr),
    .mem_busy(mem_busy), .fwd_a(fa[0]), .fwd_b(fb[0]), .stall_fe(sf[0]), .bubble_ex(bx[0]),
    .freeze(fz[0]), .stall_cnt(c0)
  );

  hazard_fwd_unit #(.REG_AW(3), .ZERO_REG(1'b1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_rs_v(id_rs_v), .id_rt_v(id_rt_v),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rs_v(ex_rs_v), .ex_rt_v(ex_rt_v), .ex_rd(ex_rd),
    .ex_wr(ex_wr), .ex_ld(ex_ld), .xm_rd(xm_rd), .xm_wr(xm_wr), .mwb_rd(mwb_rd), .mwb_wr(mwb_wr),
    .mem_busy(mem_busy), .fwd_a(fa[1]), .fwd_b(fb[1]), .stall_fe(sf[1]), .bubble_ex(bx[1]),
    .freeze(fz[1]), .stall_cnt(c1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input int zr, input logic [2:0] src, input logic v);
    if (!v || (zr != 0 && src == 3'd0)) return 2'b00;
    if (xm_wr && xm_rd == src) return 2'b10;
    if (mwb_wr && mwb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int lu_ref(input int zr);
    if (!(ex_ld && ex_wr)) return 0;
    if (zr != 0 && ex_rd == 3'd0) return 0;
    return ((id_rs_v && id_rs == ex_rd) || (id_rt_v && id_rt == ex_rd)) ? 1 : 0;
  endfunction

  function automatic logic [31:0] cnt_of(input int d);
    return (d == 0) ? 32'(c0) : 32'(c1);
  endfunction

  task automatic clear_inputs();
    {id_rs, id_rt, ex_rs, ex_rt, ex_rd, xm_rd, mwb_rd} = '0;
    {id_rs_v, id_rt_v, ex_rs_v, ex_rt_v, ex_wr, ex_ld, xm_wr, mwb_wr, mem_busy} = '0;
  endtask

  // One clock: check outputs against the model mid-cycle, then advance the model at the edge.
  task automatic step();
    int owe_n [2];
    int pb_n  [2];
    int cnt_n [2];
    #1;
    for (int d = 0; d < 2; d++) begin
      int lu, fresh, lst, slu, e_sf, e_bx;
      lu    = lu_ref(d);
      fresh = (pb[d] == 0 && owe[d] == 0) ? 1 : 0;
      lst   = (pb[d] == 0 && owe[d] == 1) ? 1 : 0;
      slu   = (fresh != 0) ? lu : lst;
      e_sf  = (mem_busy || slu != 0) ? 1 : 0;
      e_bx  = (slu != 0 && !mem_busy) ? 1 : 0;
      chk($sformatf("fwd_a[%0d]", d), 32'(fa[d]), 32'(fwd_ref(d, ex_rs, ex_rs_v)));
      chk($sformatf("fwd_b[%0d]", d), 32'(fb[d]), 32'(fwd_ref(d, ex_rt, ex_rt_v)));
      chk($sformatf("stall_fe[%0d]", d), 32'(sf[d]), 32'(e_sf));
      chk($sformatf("bubble_ex[%0d]", d), 32'(bx[d]), 32'(e_bx));
      chk($sformatf("freeze[%0d]", d), 32'(fz[d]), 32'(mem_busy));
      chk($sformatf("stall_cnt[%0d]", d), cnt_of(d), 32'(cnt[d]));
      owe_n[d] = (fresh != 0) ? lu : ((lst != 0) ? int'(mem_busy) : owe[d]);
      pb_n[d]  = int'(mem_busy);
      cnt_n[d] = (e_sf != 0 && cnt[d] < cmax[d]) ? cnt[d] + 1 : cnt[d];
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      owe[d] = owe_n[d];
      pb[d]  = pb_n[d];
      cnt[d] = cnt_n[d];
    end
    @(negedge clk);
  endtask

  // Asynchronous reset pulse mid-cycle; stall outputs must drop at once, forwards stay live.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_stall_fe[%0d]", d), 32'(sf[d]), 32'd0);
      chk($sformatf("rst_bubble_ex[%0d]", d), 32'(bx[d]), 32'd0);
      chk($sformatf("rst_freeze[%0d]", d), 32'(fz[d]), 32'd0);
      chk($sformatf("rst_cnt[%0d]", d), cnt_of(d), 32'd0);
      chk($sformatf("rst_fwd_a[%0d]", d), 32'(fa[d]), 32'(fwd_ref(d, ex_rs, ex_rs_v)));
      owe[d] = 0;
      pb[d]  = 0;
      cnt[d] = 0;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    mem_busy = 1'b1;
    ex_ld = 1'b1; ex_wr = 1'b1; ex_rd = 3'd2; id_rs = 3'd2; id_rs_v = 1'b1;
    do_reset();
    clear_inputs();
    step();

    // Forward priority and fallback.
    xm_wr = 1'b1; xm_rd = 3'd3; mwb_wr = 1'b1; mwb_rd = 3'd3; ex_rs = 3'd3; ex_rs_v = 1'b1;
    #1 chk("fwd_prio", 32'(fa[0]), 32'd2);
    step();
    xm_wr = 1'b0;
    #1 chk("fwd_mwb", 32'(fa[0]), 32'd1);
    step();
    clear_inputs();

    // Load-use: two stall cycles then release.
    do_reset();
    ex_ld = 1'b1; ex_wr = 1'b1; ex_rd = 3'd5; id_rt = 3'd5; id_rt_v = 1'b1;
    step();
    clear_inputs();
    step();
    step();
    step();
    chk("lu_cnt", 32'(c0), 32'd2);

    // Unread source and hardwired zero.
    ex_ld = 1'b1; ex_wr = 1'b1; ex_rd = 3'd5; id_rt = 3'd5; id_rt_v = 1'b0;
    step();
    clear_inputs();
    ex_ld = 1'b1; ex_wr = 1'b1; ex_rd = 3'd0; id_rs = 3'd0; id_rs_v = 1'b1;
    xm_wr = 1'b1; xm_rd = 3'd0; ex_rs = 3'd0; ex_rs_v = 1'b1; ex_rt = 3'd0; ex_rt_v = 1'b1;
    step();
    clear_inputs();
    step();
    step();

    // Load-use coincident with a three-cycle memory stall.
    do_reset();
    ex_ld = 1'b1; ex_wr = 1'b1; ex_rd = 3'd4; id_rs = 3'd4; id_rs_v = 1'b1; mem_busy = 1'b1;
    step(); step(); step();
    clear_inputs();
    step(); step(); step(); step();

    // Long freeze saturates the narrow counter.
    mem_busy = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("sat_cnt", 32'(c1), 32'd15);
    clear_inputs();
    step();

    // Reset while waiting on memory with a stall pending.
    ex_ld = 1'b1; ex_wr = 1'b1; ex_rd = 3'd6; id_rt = 3'd6; id_rt_v = 1'b1; mem_busy = 1'b1;
    step(); step();
    do_reset();
    clear_inputs();
    step(); step(); step();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      id_rs = 3'($urandom_range(7)); id_rt = 3'($urandom_range(7));
      ex_rs = 3'($urandom_range(7)); ex_rt = 3'($urandom_range(7));
      ex_rd = 3'($urandom_range(7)); xm_rd = 3'($urandom_range(7)); mwb_rd = 3'($urandom_range(7));
      id_rs_v = 1'($urandom_range(1)); id_rt_v = 1'($urandom_range(1));
      ex_rs_v = 1'($urandom_range(1)); ex_rt_v = 1'($urandom_range(1));
      ex_wr = 1'($urandom_range(1)); ex_ld = 1'($urandom_range(1));
      xm_wr = 1'($urandom_range(1)); mwb_wr = 1'($urandom_range(1));
      mem_busy = ($urandom_range(3) == 0);
      if ($urandom_range(63) == 0) do_reset();
      else step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
